// File: rtl/traffic_light_controller.sv
// Single-approach traffic-light sequencer: RED -> GREEN -> YELLOW -> RED,
// each phase held for a parameterised number of cycles, Moore-decoded lamps.
module traffic_light_controller #(
    parameter int RED_CYCLES    = 4,
    parameter int GREEN_CYCLES  = 3,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam logic [1:0] ST_RED    = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    generate
        if (RED_CYCLES < 1 || longint'(RED_CYCLES) > CNT_SPAN) begin : g_bad_red
            $error("RED_CYCLES out of range for CNT_W");
        end
        if (GREEN_CYCLES < 1 || longint'(GREEN_CYCLES) > CNT_SPAN) begin : g_bad_green
            $error("GREEN_CYCLES out of range for CNT_W");
        end
        if (YELLOW_CYCLES < 1 || longint'(YELLOW_CYCLES) > CNT_SPAN) begin : g_bad_yellow
            $error("YELLOW_CYCLES out of range for CNT_W");
        end
    endgenerate

    // Last count value of each phase, truncated to the counter width.
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_RED: begin
                if (cnt_q == RED_LAST) begin
                    state_d = ST_GREEN;
                    cnt_d   = '0;
                end
            end
            ST_GREEN: begin
                if (cnt_q == GREEN_LAST) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = ST_RED;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Unused encoding recovers straight into a fresh RED phase.
                state_d = ST_RED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Red also covers the unused encoding so exactly one lamp is always lit.
    always_comb begin
        green  = (state_q == ST_GREEN);
        yellow = (state_q == ST_YELLOW);
        red    = (state_q != ST_GREEN) && (state_q != ST_YELLOW);
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: default 4/3/2 instance plus a
// 1/1/1 instance, expected lamps/count derived from edges since reset.
module tb_traffic_light_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic red, yellow, green;
    logic red_f, yellow_f, green_f;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int kf       = 0;

    // {red, yellow, green, cnt[7:0]}
    logic [10:0] exp_q[$];
    logic [10:0] exp_f_q[$];

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk    (clk),
        .reset  (reset),
        .red    (red),
        .yellow (yellow),
        .green  (green)
    );

    traffic_light_controller #(
        .RED_CYCLES    (1),
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1)
    ) dut_f (
        .clk    (clk),
        .reset  (reset),
        .red    (red_f),
        .yellow (yellow_f),
        .green  (green_f)
    );

    function automatic logic [10:0] expect_of(int kk, int r, int g, int y);
        int p;
        p = kk % (r + g + y);
        if (p < r)          return {3'b100, 8'(p)};
        else if (p < r + g) return {3'b001, 8'(p - r)};
        else                return {3'b010, 8'(p - r - g)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [10:0] e;
        logic [10:0] ef;
        if (exp_q.size() == 0 || exp_f_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e  = exp_q.pop_front();
        ef = exp_f_q.pop_front();
        check("lamps",   {29'd0, red, yellow, green}, {29'd0, e[10:8]});
        check("cnt",     {24'd0, dut.cnt_q}, {24'd0, e[7:0]});
        check("onehot",  $countones({red, yellow, green}), 32'd1);
        check("lamps_f", {29'd0, red_f, yellow_f, green_f}, {29'd0, ef[10:8]});
        check("cnt_f",   {24'd0, dut_f.cnt_q}, {24'd0, ef[7:0]});
    endtask

    task automatic step(input logic rst_v);
        @(negedge clk);
        reset = rst_v;
        @(posedge clk);
        if (rst_v) begin
            k  = 0;
            kf = 0;
        end else begin
            k++;
            kf++;
        end
        exp_q.push_back(expect_of(k, 4, 3, 2));
        exp_f_q.push_back(expect_of(kf, 1, 1, 1));
        #1;
        compare_outputs();
    endtask

    task automatic illegal_step();
        @(negedge clk);
        reset = 1'b0;
        force dut.state_q = 2'b11;
        #1;
        check("illegal_lamps", {29'd0, red, yellow, green}, 32'b100);
        release dut.state_q;
        @(posedge clk);
        k = 0;
        kf++;
        exp_q.push_back(expect_of(k, 4, 3, 2));
        exp_f_q.push_back(expect_of(kf, 1, 1, 1));
        #1;
        compare_outputs();
        check("illegal_state", {30'd0, dut.state_q}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b1);
        for (int i = 0; i < 36; i++) step(1'b0);
        // k is now a multiple of 9; advance into mid-GREEN, then reset.
        for (int i = 0; i < 5; i++) step(1'b0);
        check("mid_green", {31'd0, green}, 32'd1);
        step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 5; i++) step(1'b0);
        check("pre_illegal_green", {31'd0, green}, 32'd1);
        illegal_step();
        for (int i = 0; i < 12; i++) step(1'b0);
        check("scoreboard_drained", 32'(exp_q.size() + exp_f_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
